// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases per-domain active-low resets one at a time after the synchronized reset.
// Optional software reset (re-assert all, re-run sequence, counted) is enabled by RST_SEQ_SW_RST_EN.
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS = 3,
    parameter int DLY_CYCLES  = 8,
    parameter int SW_HOLD     = 4,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    output logic [NUM_DOMAINS-1:0] DOM_RST,
    output logic                   SEQ_DONE,
    output logic [7:0]             SW_RST_CNT
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [CNT_WIDTH-1:0] DLY_LAST  = CNT_WIDTH'(DLY_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(SW_HOLD - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        ST_SEQ   = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWRST = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic                   seq_done_q, seq_done_d;
    logic                   sw_accept;

`ifdef RST_SEQ_SW_RST_EN
    // Requests only take effect in RUN; elsewhere they are dropped, not queued.
    assign sw_accept = (state_q == ST_RUN) && SW_RST_REQ;

    logic [7:0] sw_cnt_q, sw_cnt_d;

    always_comb begin
        sw_cnt_d = sw_cnt_q;
        if (sw_accept && (sw_cnt_q != 8'hFF)) begin
            sw_cnt_d = sw_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sw_cnt_q <= 8'd0;
        end else begin
            sw_cnt_q <= sw_cnt_d;
        end
    end

    assign SW_RST_CNT = sw_cnt_q;
`else
    logic unused_sw_req;
    assign unused_sw_req = SW_RST_REQ;
    assign sw_accept     = 1'b0;
    assign SW_RST_CNT    = 8'd0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        dom_rst_d  = dom_rst_q;
        seq_done_d = seq_done_q;
        case (state_q)
            ST_SEQ: begin
                if (cnt_q == DLY_LAST) begin
                    dom_rst_d[idx_q] = 1'b1;
                    cnt_d            = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d      = '0;
                        seq_done_d = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (sw_accept) begin
                    dom_rst_d  = '0;
                    seq_done_d = 1'b0;
                    cnt_d      = '0;
                    idx_d      = '0;
                    state_d    = ST_SWRST;
                end
            end
            ST_SWRST: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SEQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SEQ;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_SEQ;
            cnt_q      <= '0;
            idx_q      <= '0;
            dom_rst_q  <= '0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            dom_rst_q  <= dom_rst_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign DOM_RST  = dom_rst_q;
    assign SEQ_DONE = seq_done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed testbench for rst_seq_ctrl with default parameters.
// Software-reset scenarios run when RST_SEQ_SW_RST_EN is defined; otherwise the disabled behaviour is checked.
module tb_rst_seq_ctrl;

    localparam int ND   = 3;
    localparam int DLY  = 8;
    localparam int HOLD = 4;
    localparam int SEQ_LEN = ND * DLY;

    logic          CLK;
    logic          RST;
    logic          SW_RST_REQ;
    logic [ND-1:0] DOM_RST;
    logic          SEQ_DONE;
    logic [7:0]    SW_RST_CNT;

    int n_tests = 0;
    int n_fail  = 0;

    rst_seq_ctrl #(
        .NUM_DOMAINS(ND),
        .DLY_CYCLES (DLY),
        .SW_HOLD    (HOLD),
        .CNT_WIDTH  (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SW_RST_REQ(SW_RST_REQ),
        .DOM_RST   (DOM_RST),
        .SEQ_DONE  (SEQ_DONE),
        .SW_RST_CNT(SW_RST_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Bit k is released once e >= (k+1)*DLY edges have elapsed in the sequence.
    function automatic logic [ND-1:0] exp_dom(input int e);
        logic [ND-1:0] v;
        v = '0;
        for (int k = 0; k < ND; k++) begin
            if (e >= (k + 1) * DLY) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Advance n rising edges; returns at the following falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b0;
        step(2);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        #1 RST = 1'b0;
        #1;
        n_tests++;
        if (DOM_RST !== 3'b000 || SEQ_DONE !== 1'b0 || SW_RST_CNT !== 8'd0) begin
            n_fail++;
            $display("FAIL reset: DOM_RST=%b SEQ_DONE=%b CNT=%0d, want 000/0/0", DOM_RST, SEQ_DONE, SW_RST_CNT);
        end
        step(2);
        RST = 1'b1;
    endtask

    task automatic test_power_up();
        apply_reset();
        for (int e = 1; e <= SEQ_LEN + 2; e++) begin
            step(1);
            n_tests++;
            if (DOM_RST !== exp_dom(e) || SEQ_DONE !== (e >= SEQ_LEN) || SW_RST_CNT !== 8'd0) begin
                n_fail++;
                $display("FAIL power_up edge %0d: DOM_RST=%b SEQ_DONE=%b CNT=%0d, want %b/%b/0",
                         e, DOM_RST, SEQ_DONE, SW_RST_CNT, exp_dom(e), (e >= SEQ_LEN));
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(12);
        n_tests++;
        if (DOM_RST !== 3'b001) begin
            n_fail++;
            $display("FAIL async_pre edge 12: DOM_RST=%b, want 001", DOM_RST);
        end
        #1 RST = 1'b0;
        #1;
        n_tests++;
        if (DOM_RST !== 3'b000 || SEQ_DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL async_assert: DOM_RST=%b SEQ_DONE=%b, want 000/0", DOM_RST, SEQ_DONE);
        end
        @(negedge CLK);
        RST = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step(1);
            n_tests++;
            if (DOM_RST !== exp_dom(e)) begin
                n_fail++;
                $display("FAIL async_restart edge %0d: DOM_RST=%b, want %b", e, DOM_RST, exp_dom(e));
            end
        end
    endtask

`ifdef RST_SEQ_SW_RST_EN
    task automatic test_sw_reset();
        apply_reset();
        step(SEQ_LEN + 3);
        SW_RST_REQ = 1'b1;
        step(1);
        SW_RST_REQ = 1'b0;
        n_tests++;
        if (DOM_RST !== 3'b000 || SEQ_DONE !== 1'b0 || SW_RST_CNT !== 8'd1) begin
            n_fail++;
            $display("FAIL sw_reset t: DOM_RST=%b SEQ_DONE=%b CNT=%0d, want 000/0/1", DOM_RST, SEQ_DONE, SW_RST_CNT);
        end
        for (int off = 1; off <= HOLD + SEQ_LEN + 1; off++) begin
            step(1);
            n_tests++;
            if (DOM_RST !== exp_dom(off - HOLD) || SEQ_DONE !== (off >= HOLD + SEQ_LEN) || SW_RST_CNT !== 8'd1) begin
                n_fail++;
                $display("FAIL sw_reset t+%0d: DOM_RST=%b SEQ_DONE=%b CNT=%0d, want %b/%b/1",
                         off, DOM_RST, SEQ_DONE, SW_RST_CNT, exp_dom(off - HOLD), (off >= HOLD + SEQ_LEN));
            end
        end
    endtask

    task automatic test_ignored_outside_run();
        apply_reset();
        for (int e = 1; e <= SEQ_LEN + 3; e++) begin
            if (e == 3) SW_RST_REQ = 1'b1;
            if (e == 21) SW_RST_REQ = 1'b0;
            step(1);
            n_tests++;
            if (DOM_RST !== exp_dom(e) || SEQ_DONE !== (e >= SEQ_LEN) || SW_RST_CNT !== 8'd0) begin
                n_fail++;
                $display("FAIL ignored edge %0d: DOM_RST=%b SEQ_DONE=%b CNT=%0d, want %b/%b/0",
                         e, DOM_RST, SEQ_DONE, SW_RST_CNT, exp_dom(e), (e >= SEQ_LEN));
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        step(SEQ_LEN);
        SW_RST_REQ = 1'b1;
        step(1);
        step(HOLD + SEQ_LEN);
        n_tests++;
        if (DOM_RST !== 3'b111 || SEQ_DONE !== 1'b1 || SW_RST_CNT !== 8'd1) begin
            n_fail++;
            $display("FAIL b2b_run: DOM_RST=%b SEQ_DONE=%b CNT=%0d, want 111/1/1", DOM_RST, SEQ_DONE, SW_RST_CNT);
        end
        step(1);
        SW_RST_REQ = 1'b0;
        n_tests++;
        if (DOM_RST !== 3'b000 || SEQ_DONE !== 1'b0 || SW_RST_CNT !== 8'd2) begin
            n_fail++;
            $display("FAIL b2b_retrigger: DOM_RST=%b SEQ_DONE=%b CNT=%0d, want 000/0/2", DOM_RST, SEQ_DONE, SW_RST_CNT);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        apply_reset();
        step(SEQ_LEN);
        for (int i = 1; i <= 257; i++) begin
            SW_RST_REQ = 1'b1;
            step(1);
            SW_RST_REQ = 1'b0;
            step(HOLD + SEQ_LEN);
            exp_cnt = (i > 255) ? 255 : i;
            n_tests++;
            if (SW_RST_CNT !== exp_cnt[7:0] || SEQ_DONE !== 1'b1) begin
                n_fail++;
                $display("FAIL saturation req %0d: CNT=%0d SEQ_DONE=%b, want %0d/1", i, SW_RST_CNT, SEQ_DONE, exp_cnt);
            end
        end
    endtask
`else
    task automatic test_macro_off();
        apply_reset();
        step(SEQ_LEN + 2);
        SW_RST_REQ = 1'b1;
        step(1);
        SW_RST_REQ = 1'b0;
        for (int e = 0; e < 6; e++) begin
            n_tests++;
            if (DOM_RST !== 3'b111 || SEQ_DONE !== 1'b1 || SW_RST_CNT !== 8'd0) begin
                n_fail++;
                $display("FAIL macro_off +%0d: DOM_RST=%b SEQ_DONE=%b CNT=%0d, want 111/1/0",
                         e, DOM_RST, SEQ_DONE, SW_RST_CNT);
            end
            step(1);
        end
        SW_RST_REQ = 1'b1;
        step(HOLD + SEQ_LEN + 4);
        SW_RST_REQ = 1'b0;
        n_tests++;
        if (DOM_RST !== 3'b111 || SEQ_DONE !== 1'b1 || SW_RST_CNT !== 8'd0) begin
            n_fail++;
            $display("FAIL macro_off_held: DOM_RST=%b SEQ_DONE=%b CNT=%0d, want 111/1/0", DOM_RST, SEQ_DONE, SW_RST_CNT);
        end
    endtask
`endif

    initial begin
        RST        = 1'b0;
        SW_RST_REQ = 1'b0;
        step(3);
        RST = 1'b1;
        test_reset();
        test_power_up();
        test_async_reset();
`ifdef RST_SEQ_SW_RST_EN
        test_sw_reset();
        test_ignored_outside_run();
        test_back_to_back();
        test_saturation();
`else
        test_macro_off();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
